// File: rtl/dioptase_fetch_pkg.sv
// Shared definitions for the Dioptase instruction-fetch front end.
//   EXC_FETCH_MISALIGNED : fetch exception code for a PC with nonzero low bits
//   fetch_entry_t        : one fetched instruction {instr, pc, exc}
//   fetch_depth()        : return-queue depth for a given memory latency
//   fetch_exc()          : fetch exception code derived from the PC low bits
package dioptase_fetch_pkg;

    localparam logic [7:0] EXC_FETCH_MISALIGNED = 8'h82;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  exc;
    } fetch_entry_t;

    // One slot per in-flight read plus one, so a full pipe can still drain
    // while the head is held by decode.
    function automatic int unsigned fetch_depth(input int unsigned mem_latency);
        return mem_latency + 1;
    endfunction

    function automatic logic [7:0] fetch_exc(input logic [1:0] pc_low);
        return (pc_low != 2'b00) ? EXC_FETCH_MISALIGNED : 8'h00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO holding returned instruction words until decode takes them.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drop all entries (has priority over push/pop)
//   push        : write push_entry at the tail
//   push_entry  : entry to write
//   pop         : retire the head entry
//   head_entry  : storage at the head pointer (meaningful only when count != 0)
//   count       : number of valid entries
module fetch_queue
    import dioptase_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head_entry,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

    // A push into a full queue without a same-cycle pop means the upstream
    // credit accounting is broken.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !clear && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues sequential word reads to a
// fixed-latency memory, tracks in-flight reads in a latency pipe and buffers
// returned words in a credit-protected queue presented to decode.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   halt         : no new requests, no consumption (returns still land)
//   stall        : decode holds the head entry
//   redirect     : squash all fetched/in-flight work, restart at redirect_pc
//   redirect_pc  : restart PC
//   mem_re       : read request this cycle
//   mem_addr     : request address (current PC)
//   mem_data     : read data, MEM_LATENCY cycles after its request
//   instr_out    : head instruction (0 on bubble or exception)
//   pc_out       : head PC (0 on bubble)
//   bubble_out   : no valid instruction presented
//   exc_out      : head fetch exception code (0 if none)
module fetch_unit
    import dioptase_fetch_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        bubble_out,
    output logic [7:0]  exc_out
);

    localparam int unsigned DEPTH = fetch_depth(MEM_LATENCY);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = 4;

    logic [31:0]                  pc_q, pc_d;
    logic [MEM_LATENCY-1:0]       pipe_valid_q, pipe_valid_d;
    logic [MEM_LATENCY-1:0][31:0] pipe_pc_q, pipe_pc_d;
    logic [MEM_LATENCY-1:0][7:0]  pipe_exc_q, pipe_exc_d;

    logic [SUM_W-1:0] inflight;
    logic             bubble;
    logic             pop;
    logic             issue;
    logic             push;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic [CNT_W-1:0] q_count;

    // Credit check: every in-flight read already owns a queue slot, so a new
    // request is allowed only if in-flight + queued (after this cycle's pop)
    // still leaves room. rst_n gates issue so nothing is requested in reset.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + SUM_W'(pipe_valid_q[i]);
        end
        bubble = (q_count == '0);
        pop    = !bubble && !stall && !halt && !redirect;
        issue  = rst_n && !halt && !redirect &&
                 ((inflight + SUM_W'(q_count)) < (SUM_W'(DEPTH) + SUM_W'(pop)));
    end

    // The latency pipe shifts unconditionally; a redirect kills every slot,
    // including the one whose data is returning this cycle.
    always_comb begin
        pipe_valid_d  = '0;
        pipe_pc_d     = pipe_pc_q;
        pipe_exc_d    = pipe_exc_q;
        pipe_valid_d[0] = issue;
        pipe_pc_d[0]    = pc_q;
        pipe_exc_d[0]   = fetch_exc(pc_q[1:0]);
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1] && !redirect;
            pipe_pc_d[i]    = pipe_pc_q[i-1];
            pipe_exc_d[i]   = pipe_exc_q[i-1];
        end

        push             = pipe_valid_q[MEM_LATENCY-1] && !redirect;
        push_entry.pc    = pipe_pc_q[MEM_LATENCY-1];
        push_entry.exc   = pipe_exc_q[MEM_LATENCY-1];
        push_entry.instr = (pipe_exc_q[MEM_LATENCY-1] != 8'h00) ? 32'h0 : mem_data;

        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            pipe_valid_q <= '0;
            pipe_pc_q    <= '0;
            pipe_exc_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_pc_q    <= pipe_pc_d;
            pipe_exc_q   <= pipe_exc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (q_count)
    );

    assign mem_re     = issue;
    assign mem_addr   = pc_q;
    assign bubble_out = bubble;
    assign instr_out  = bubble ? 32'h0 : head_entry.instr;
    assign pc_out     = bubble ? 32'h0 : head_entry.pc;
    assign exc_out    = bubble ? 8'h00 : head_entry.exc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// halt/stall/redirect traffic, compared every cycle against a transaction
// model built from in-flight request timestamps and an output queue.
module tb_fetch_unit;

    localparam int          LAT    = 2;
    localparam int          DEPTH  = LAT + 1;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        bubble_out;
    logic [7:0]  exc_out;

    always #5 clk = ~clk;

    fetch_unit #(
        .MEM_LATENCY (LAT),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (halt),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .bubble_out  (bubble_out),
        .exc_out     (exc_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  exc;
        int          ready;
    } flight_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  exc;
    } entry_t;

    int          testsRun  = 0;
    int          testsFail = 0;
    int          cyc       = 0;
    flight_t     flights[$];
    entry_t      outQ[$];
    logic [31:0] modelPc;
    logic        expIssue;
    logic        expPop;
    logic        histValid [16];
    logic [31:0] histAddr  [16];

    // Memory contents: a fixed scramble of the address, distinct from the PC.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [7:0] expExc(input logic [31:0] a);
        return (a[1:0] != 2'b00) ? 8'h82 : 8'h00;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFail++;
            $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkValue({tag, "_mem_re"},   {31'b0, mem_re},     32'h0);
        checkValue({tag, "_mem_addr"}, mem_addr,            RST_PC);
        checkValue({tag, "_bubble"},   {31'b0, bubble_out}, 32'h1);
        checkValue({tag, "_instr"},    instr_out,           32'h0);
        checkValue({tag, "_pc"},       pc_out,              32'h0);
        checkValue({tag, "_exc"},      {24'b0, exc_out},    32'h0);
    endtask

    task automatic modelReset();
        flights.delete();
        outQ.delete();
        modelPc = RST_PC;
        for (int i = 0; i < 16; i++) begin
            histValid[i] = 1'b0;
            histAddr[i]  = '0;
        end
    endtask

    // Drive one cycle's inputs mid-cycle; the memory answers requests seen
    // LAT cycles earlier, otherwise it returns junk.
    task automatic applyStimulus(input logic st, input logic hl, input logic rd, input logic [31:0] rpc);
        int h;
        @(negedge clk);
        stall       = st;
        halt        = hl;
        redirect    = rd;
        redirect_pc = rpc;
        h = (cyc - LAT) & 15;
        if (cyc >= LAT && histValid[h]) begin
            mem_data = memWord(histAddr[h]);
        end else begin
            mem_data = $urandom();
        end
        #1;
    endtask

    task automatic checkOutput();
        int occupancy;
        expPop    = (outQ.size() != 0) && !stall && !halt && !redirect;
        occupancy = flights.size() + outQ.size() - (expPop ? 1 : 0);
        expIssue  = !halt && !redirect && (occupancy < DEPTH);
        checkValue("mem_re",   {31'b0, mem_re}, {31'b0, expIssue});
        checkValue("mem_addr", mem_addr,        modelPc);
        if (outQ.size() == 0) begin
            checkValue("bubble", {31'b0, bubble_out}, 32'h1);
            checkValue("pc",     pc_out,              32'h0);
            checkValue("instr",  instr_out,           32'h0);
            checkValue("exc",    {24'b0, exc_out},    32'h0);
        end else begin
            checkValue("bubble", {31'b0, bubble_out}, 32'h0);
            checkValue("pc",     pc_out,              outQ[0].pc);
            checkValue("instr",  instr_out,           outQ[0].instr);
            checkValue("exc",    {24'b0, exc_out},    {24'b0, outQ[0].exc});
        end
    endtask

    task automatic advanceModel();
        flight_t f;
        entry_t  e;
        entry_t  dropped;
        histValid[cyc & 15] = mem_re;
        histAddr[cyc & 15]  = mem_addr;
        if (redirect) begin
            flights.delete();
            outQ.delete();
            modelPc = redirect_pc;
        end else begin
            if (expPop) begin
                dropped = outQ.pop_front();
            end
            if (flights.size() > 0 && flights[0].ready == cyc) begin
                f       = flights.pop_front();
                e.pc    = f.pc;
                e.exc   = f.exc;
                e.instr = (f.exc != 8'h00) ? 32'h0 : memWord(f.pc);
                outQ.push_back(e);
            end
            if (expIssue) begin
                f.pc    = modelPc;
                f.exc   = expExc(modelPc);
                f.ready = cyc + LAT;
                flights.push_back(f);
                modelPc = modelPc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic step(input logic st, input logic hl, input logic rd, input logic [31:0] rpc);
        applyStimulus(st, hl, rd, rpc);
        checkOutput();
        advanceModel();
    endtask

    initial begin
        logic [31:0] rpc;
        rst_n       = 1'b0;
        halt        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_data    = '0;
        modelReset();

        repeat (3) @(posedge clk);
        #2;
        checkReset("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Pipeline fill: first valid output three cycles after the first request.
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("first_valid", {31'b0, bubble_out}, 32'h0);
        checkValue("first_pc",    pc_out,              32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("second_pc",   pc_out,              32'h4);

        // Long stall: head frozen, requests stop once credits run out.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        checkValue("stall_frozen_pc", pc_out,          32'h8);
        checkValue("stall_no_credit", {31'b0, mem_re}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("release_pc", pc_out, 32'hC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("resume_no_gap", pc_out, 32'h14);

        // Redirect penalty: three bubbles, then the new target.
        step(1'b0, 1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            checkValue("redirect_bubble", {31'b0, bubble_out}, 32'h1);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("redirect_target", pc_out, 32'h100);

        // Misaligned target: entry carries the exception and no instruction.
        step(1'b0, 1'b0, 1'b1, 32'h102);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("misalign_pc",    pc_out,           32'h102);
        checkValue("misalign_exc",   {24'b0, exc_out}, 32'h82);
        checkValue("misalign_instr", instr_out,        32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("misalign_next", pc_out, 32'h106);

        // Halt blocks issue; then stall+redirect together, target near the wrap.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            checkValue("halt_no_issue", {31'b0, mem_re}, 32'h0);
        end
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF4);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            checkValue("wrap_pc", pc_out, 32'hFFFF_FFF4 + 32'(4 * i));
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            rpc = $urandom();
            case ($urandom_range(0, 3))
                0:       rpc = {rpc[31:2], 2'b00};
                1:       rpc = 32'hFFFF_FFE0 | (rpc & 32'h0000_001F);
                2:       rpc = rpc & 32'h0000_0FFF;
                default: rpc = rpc;
            endcase
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 24) == 0), rpc);
        end

        // Asynchronous reset in the middle of a stalled stream.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async_reset");
        modelReset();
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkReset("held_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("restart_pc",    pc_out,              RST_PC);
        checkValue("restart_valid", {31'b0, bubble_out}, 32'h0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
